// File: rtl/cal_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cal_pkg : shared types, address encoding and saturation helper      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package cal_pkg;

  localparam logic SEL_OFFSET = 1'b0;
  localparam logic SEL_GAIN   = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input logic signed [63:0] lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cal_coef_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cal_coef_bank : double-buffered offset/gain bank, copy on strobe    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cal_coef_bank
  import cal_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int W      = 16,
  parameter int FRAC   = 10,
  parameter int ADDR_W = $clog2(2*N_CH),
  parameter int IW     = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic signed [W-1:0] wdata_i,
  input  logic                copy_i,
  input  logic [IW-1:0]       rd_idx_i,
  output logic signed [W-1:0] off_o,
  output logic signed [W-1:0] gain_o
);

  localparam logic signed [W-1:0] C_UNITY = W'(1 << FRAC);
  localparam logic [ADDR_W-1:0]   C_NCH   = ADDR_W'(N_CH);

  logic signed [W-1:0] off_sh_q  [N_CH];
  logic signed [W-1:0] gain_sh_q [N_CH];
  logic signed [W-1:0] off_act_q [N_CH];
  logic signed [W-1:0] gain_act_q[N_CH];

  logic [ADDR_W-2:0] wch;
  logic              wr_ok;
  assign wch   = addr_i[ADDR_W-1:1];
  assign wr_ok = we_i && ({1'b0, wch} < C_NCH);

  // The copy reads the pre-edge shadow, so a write on the copy edge lands in the next pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        off_sh_q[i]   <= '0;
        gain_sh_q[i]  <= C_UNITY;
        off_act_q[i]  <= '0;
        gain_act_q[i] <= C_UNITY;
      end
    end else begin
      if (wr_ok) begin
        if (addr_i[0] == SEL_GAIN) gain_sh_q[wch] <= wdata_i;
        else                       off_sh_q[wch]  <= wdata_i;
      end
      if (copy_i) begin
        for (int i = 0; i < N_CH; i++) begin
          off_act_q[i]  <= off_sh_q[i];
          gain_act_q[i] <= gain_sh_q[i];
        end
      end
    end
  end

  assign off_o  = off_act_q[rd_idx_i];
  assign gain_o = gain_act_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/cal_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cal_pipeline : sequenced per-channel offset/gain calibrator         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cal_pipeline
  import cal_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int W      = 16,
  parameter int FRAC   = 10,
  parameter int CLAMP  = 32000,
  parameter int ADDR_W = $clog2(2*N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_strobe,
  input  logic                bypass,
  input  logic [N_CH*W-1:0]   sample_in,
  output logic [N_CH*W-1:0]   sample_out,
  output logic                out_valid,
  output logic                busy,
  output logic                overrun,
  input  logic                overrun_clr,
  input  logic                cal_we,
  input  logic [ADDR_W-1:0]   cal_addr,
  input  logic [W-1:0]        cal_wdata
);

  localparam int CW = $clog2(N_CH + 1);
  localparam int IW = $clog2(N_CH);
  localparam int PW = 2*W + 1;
  localparam logic [CW-1:0] C_NCH = CW'(N_CH);

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 byp_q;
  logic signed [W-1:0]  in_q  [N_CH];
  logic signed [W-1:0]  res_q [N_CH];
  logic signed [PW-1:0] p_q;
  logic                 s1_vld_q;
  logic [IW-1:0]        s1_ch_q;
  logic [N_CH*W-1:0]    sample_out_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic                 overrun_q;

  logic                 strobe_acc;
  logic [IW-1:0]        idx;
  logic signed [W-1:0]  off_w;
  logic signed [W-1:0]  gain_w;
  logic signed [W:0]    d;
  logic signed [PW-1:0] p_d;
  logic signed [PW-1:0] shf;
  logic signed [W-1:0]  r;
  logic [N_CH*W-1:0]    out_d;

  assign strobe_acc = sample_strobe && (state_q == IDLE);
  assign idx = (cnt_q < C_NCH) ? cnt_q[IW-1:0] : IW'(N_CH - 1);

  cal_coef_bank #(
    .N_CH   (N_CH),
    .W      (W),
    .FRAC   (FRAC),
    .ADDR_W (ADDR_W),
    .IW     (IW)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (cal_we),
    .addr_i   (cal_addr),
    .wdata_i  (cal_wdata),
    .copy_i   (strobe_acc),
    .rd_idx_i (idx),
    .off_o    (off_w),
    .gain_o   (gain_w)
  );

  assign d   = {in_q[idx][W-1], in_q[idx]} - {off_w[W-1], off_w};
  assign p_d = byp_q ? PW'(in_q[idx]) : PW'(d) * PW'(gain_w);
  assign shf = p_q >>> FRAC;
  assign r   = byp_q ? p_q[W-1:0] : W'(saturate(64'(shf), 64'(CLAMP)));

  // The last channel's result is merged straight from stage 2 so all channels publish together.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      out_d[i*W +: W] = (i == N_CH - 1) ? r : res_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      byp_q        <= 1'b0;
      p_q          <= '0;
      s1_vld_q     <= 1'b0;
      s1_ch_q      <= '0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        in_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      overrun_q   <= (sample_strobe && busy_q) || (overrun_q && !overrun_clr);
      if (s1_vld_q) res_q[s1_ch_q] <= r;
      case (state_q)
        IDLE: begin
          if (sample_strobe) begin
            for (int i = 0; i < N_CH; i++) in_q[i] <= sample_in[i*W +: W];
            byp_q   <= bypass;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (cnt_q < C_NCH) begin
            s1_vld_q <= 1'b1;
            s1_ch_q  <= idx;
            p_q      <= p_d;
            cnt_q    <= cnt_q + 1'b1;
          end else begin
            sample_out_q <= out_d;
            out_valid_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_cal_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cal_pipeline : directed vectors with queue scoreboard            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_cal_pipeline;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_strobe = 1'b0;
  logic        bypass = 1'b0;
  logic [63:0] sample_in = '0;
  logic [63:0] sample_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;
  logic        overrun_clr = 1'b0;
  logic        cal_we = 1'b0;
  logic [2:0]  cal_addr = '0;
  logic [15:0] cal_wdata = '0;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  cal_pipeline dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .bypass        (bypass),
    .sample_in     (sample_in),
    .sample_out    (sample_out),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .cal_we        (cal_we),
    .cal_addr      (cal_addr),
    .cal_wdata     (cal_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int e);
    return {16'(e), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every out_valid pops one expected vector and compares channel by channel.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid actual=%h required=none", sample_out);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (sample_out[i*16 +: 16] !== e[i*16 +: 16]) begin
            failures++;
            $display("FAIL ch%0d_out actual=%0d required=%0d", i,
                     $signed(sample_out[i*16 +: 16]), $signed(e[i*16 +: 16]));
          end
        end
      end
    end
  end

  task automatic wr(input logic [2:0] a, input int v);
    cal_we = 1'b1; cal_addr = a; cal_wdata = 16'(v);
    @(posedge clk); #1;
    cal_we = 1'b0;
  endtask

  // Drives one pass; wr_at/str_at = k places a write/extra strobe on edge E(k+1).
  task automatic run_pass(input logic [63:0] din, input logic byp, input logic [63:0] dexp,
                          input int wr_at, input logic [2:0] wa, input int wd, input int str_at);
    int n;
    bit got;
    sample_in = din; bypass = byp;
    exp_q.push_back(dexp);
    sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    sample_in = ~din;
    bypass = ~byp;
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      if (n == wr_at) begin cal_we = 1'b1; cal_addr = wa; cal_wdata = 16'(wd); end
      if (n == str_at) begin sample_strobe = 1'b1; overrun_clr = 1'b1; end
      @(posedge clk); #1;
      n++;
      cal_we = 1'b0; sample_strobe = 1'b0; overrun_clr = 1'b0;
      if (out_valid) got = 1'b1;
    end
    chk("latency", 64'(got ? n : 99), 64'd5);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample_out", sample_out, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_pass(pk(1000, -1000, 0, 32767), 1'b0, pk(1000, -1000, 0, 32000), -1, 0, 0, -1);

    wr(3'd2, 100);
    wr(3'd3, 2048);
    run_pass(pk(0, 1100, 5, -7), 1'b0, pk(0, 2000, 5, -7), -1, 0, 0, -1);
    run_pass(pk(-3, -16000, -32768, 7), 1'b0, pk(-3, -32000, -32000, 7), -1, 0, 0, -1);

    wr(3'd1, 4096);
    run_pass(pk(20000, 1100, 32767, -32768), 1'b1, pk(20000, 1100, 32767, -32768), -1, 0, 0, -1);
    run_pass(pk(1000, 1100, 0, 0), 1'b0, pk(4000, 2000, 0, 0), -1, 0, 0, -1);

    wr(3'd1, 1024);
    run_pass(pk(800, 0, 0, 0), 1'b0, pk(800, -200, 0, 0), 1, 3'd1, 512, -1);
    run_pass(pk(800, 0, 0, 0), 1'b0, pk(400, -200, 0, 0), -1, 0, 0, -1);

    // Extra strobe at E3 coincides with overrun_clr: set must win.
    run_pass(pk(10, 20, 30, 40), 1'b0, pk(5, -160, 30, 40), -1, 0, 0, 2);
    chk("overrun_set", 64'(overrun), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("overrun_sticky", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    chk("overrun_cleared", 64'(overrun), 64'd0);
    run_pass(pk(-10, 1100, 0, 0), 1'b0, pk(-5, 2000, 0, 0), -1, 0, 0, -1);
    run_pass(pk(2048, 0, 1, -1), 1'b0, pk(1024, -200, 1, -1), -1, 0, 0, -1);
    chk("no_overrun_min_period", 64'(overrun), 64'd0);

    sample_in = pk(1, 2, 3, 4);
    sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_sample_out", sample_out, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("postrst_sample_out", sample_out, 64'd0);
    chk("postrst_busy", 64'(busy), 64'd0);
    chk("postrst_overrun", 64'(overrun), 64'd0);
    run_pass(pk(1100, 1100, -500, 100), 1'b0, pk(1100, 1100, -500, 100), -1, 0, 0, -1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
